// File: rtl/bip_defs.sv
// Shared definitions for the BIP I control unit.
// Holds the opcode map, accumulator source encodings, the FSM state
// encoding, the decoded control word layout and the default widths.
package bip_defs;

    localparam int PC_W_DEF   = 11;
    localparam int DATA_W_DEF = 16;
    localparam int OPC_W      = 5;

    // Opcode map ([15:11] of the instruction word)
    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALTED = 3'd5
    } bip_state_e;

    // Decoded control word for one opcode
    typedef struct packed {
        logic       rd_ram;
        logic       wr_ram;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       illegal;
        logic       is_hlt;
    } bip_ctrl_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder for the BIP I control unit.
// Ports:
//   opcode_i : instruction opcode field
//   ctrl_o   : control word {rd_ram, wr_ram, wr_acc, sel_a, sel_b, op,
//              illegal, is_hlt}; the FSM registers the fields it needs
//              in the state where they become visible.
module bip_instr_decoder
    import bip_defs::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output bip_ctrl_t        ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPC_HLT: ctrl_o.is_hlt = 1'b1;
            OPC_STO: ctrl_o.wr_ram = 1'b1;
            OPC_LD: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.sel_a  = SELA_MEM;
                ctrl_o.wr_acc = 1'b1;
            end
            OPC_LDI: begin
                ctrl_o.sel_a  = SELA_IMM;
                ctrl_o.wr_acc = 1'b1;
            end
            OPC_ADD, OPC_SUB: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b0;
                ctrl_o.op     = (opcode_i == OPC_SUB);
                ctrl_o.wr_acc = 1'b1;
            end
            OPC_ADDI, OPC_SUBI: begin
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = 1'b1;
                ctrl_o.op     = (opcode_i == OPC_SUBI);
                ctrl_o.wr_acc = 1'b1;
            end
            // Undefined opcodes retire as NOPs with no strobes
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// BIP I multi-cycle control unit.
// Fetches an instruction, decodes it and drives the accumulator/ALU/MuxB
// datapath controls and data-memory strobes, retiring one instruction
// every four cycles (FETCH, DECODE, EXEC, WRITE) until HLT.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset
//   Start         : leaves IDLE (ignored elsewhere)
//   Instruction   : program memory read data (1-cycle latency after PC)
//   PC            : program memory address
//   DataAddr      : data memory address (operand field)
//   RdRam, WrRam  : data memory read / write strobes (single-cycle)
//   WrAcc         : accumulator load enable (single-cycle)
//   SelA, SelB, Op: accumulator source, ALU operand B select, add/sub
//   Immediate     : operand field sign-extended to DATA_W
//   Halted        : high while halted
//   IllegalOp     : sticky undefined-opcode flag
//   InstrCount    : retired instruction counter
//   DbgState      : current FSM state (bip_state_e encoding)
// All outputs come straight from registers.
module bip_control_unit
    import bip_defs::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Instruction,
    output logic [PC_W-1:0]   PC,
    output logic [PC_W-1:0]   DataAddr,
    output logic              RdRam,
    output logic              WrRam,
    output logic              WrAcc,
    output logic [1:0]        SelA,
    output logic              SelB,
    output logic              Op,
    output logic [DATA_W-1:0] Immediate,
    output logic              Halted,
    output logic              IllegalOp,
    output logic [15:0]       InstrCount,
    output logic [2:0]        DbgState
);

    bip_state_e        state_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] imm_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   addr_q;
    logic              rd_q;
    logic              wr_q;
    logic              wacc_q;
    logic [1:0]        sela_q;
    logic              selb_q;
    logic              op_q;
    logic              halted_q;
    logic              ill_q;
    logic [15:0]       cnt_q;

    logic [OPC_W-1:0]  dec_opcode;
    bip_ctrl_t         dec_ctrl;

    // In DECODE the IR is not loaded yet, so decode the incoming word
    // directly; afterwards decode from the IR.
    assign dec_opcode = (state_q == S_DECODE) ? Instruction[DATA_W-1 -: OPC_W]
                                              : ir_q[DATA_W-1 -: OPC_W];

    bip_instr_decoder u_decoder (
        .opcode_i (dec_opcode),
        .ctrl_o   (dec_ctrl)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wacc_q   <= 1'b0;
            sela_q   <= SELA_MEM;
            selb_q   <= 1'b0;
            op_q     <= 1'b0;
            halted_q <= 1'b0;
            ill_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // Strobes are single-cycle pulses; default them low
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            wacc_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q <= Instruction;
                    if (dec_ctrl.is_hlt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        // Address and read strobe land in EXEC so read data
                        // is back from memory by WRITE
                        state_q <= S_EXEC;
                        addr_q  <= Instruction[PC_W-1:0];
                        rd_q    <= dec_ctrl.rd_ram;
                        if (dec_ctrl.illegal) ill_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    state_q <= S_WRITE;
                    sela_q  <= dec_ctrl.sel_a;
                    selb_q  <= dec_ctrl.sel_b;
                    op_q    <= dec_ctrl.op;
                    imm_q   <= {{(DATA_W-PC_W){ir_q[PC_W-1]}}, ir_q[PC_W-1:0]};
                    wacc_q  <= dec_ctrl.wr_acc;
                    wr_q    <= dec_ctrl.wr_ram;
                end
                S_WRITE: begin
                    state_q <= S_FETCH;
                    pc_q    <= pc_q + PC_W'(1);
                    cnt_q   <= cnt_q + 16'd1;
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign PC         = pc_q;
    assign DataAddr   = addr_q;
    assign RdRam      = rd_q;
    assign WrRam      = wr_q;
    assign WrAcc      = wacc_q;
    assign SelA       = sela_q;
    assign SelB       = selb_q;
    assign Op         = op_q;
    assign Immediate  = imm_q;
    assign Halted     = halted_q;
    assign IllegalOp  = ill_q;
    assign InstrCount = cnt_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Testbench for bip_control_unit: program memory model, ISA-level
// reference model, opcode table, random programs and directed corner cases.
module tb_bip_control_unit;
    import bip_defs::*;

    localparam int PC_W   = 11;
    localparam int DATA_W = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [DATA_W-1:0] Instruction = '0;
    logic [PC_W-1:0]   PC;
    logic [PC_W-1:0]   DataAddr;
    logic              RdRam;
    logic              WrRam;
    logic              WrAcc;
    logic [1:0]        SelA;
    logic              SelB;
    logic              Op;
    logic [DATA_W-1:0] Immediate;
    logic              Halted;
    logic              IllegalOp;
    logic [15:0]       InstrCount;
    logic [2:0]        DbgState;

    bip_control_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Instruction (Instruction),
        .PC          (PC),
        .DataAddr    (DataAddr),
        .RdRam       (RdRam),
        .WrRam       (WrRam),
        .WrAcc       (WrAcc),
        .SelA        (SelA),
        .SelB        (SelB),
        .Op          (Op),
        .Immediate   (Immediate),
        .Halted      (Halted),
        .IllegalOp   (IllegalOp),
        .InstrCount  (InstrCount),
        .DbgState    (DbgState)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- program memory ----------------
    logic [15:0] prog [0:2047];
    always @(negedge Clk) Instruction = prog[PC];

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [15:0] instr;
        logic        rd;
        logic        wr;
        logic        wacc;
        logic [1:0]  sela;
        logic        selb;
        logic        op;
        logic        ill;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] mpc;
    logic [15:0] mcnt;
    logic        mill;
    bit          halted_seen;
    bit          rand_start;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rand_start) Start = 1'($urandom_range(0, 1));
    endtask

    // ISA-level reference: what an instruction should do, from the opcode table
    function automatic vec_t model_vec(input logic [15:0] instr);
        vec_t v;
        v.instr = instr;
        v.rd = 1'b0; v.wr = 1'b0; v.wacc = 1'b0;
        v.sela = 2'b00; v.selb = 1'b0; v.op = 1'b0; v.ill = 1'b0;
        case (instr[15:11])
            5'd0: ;
            5'd1: v.wr = 1'b1;
            5'd2: begin v.rd = 1'b1; v.wacc = 1'b1; v.sela = 2'b00; end
            5'd3: begin v.wacc = 1'b1; v.sela = 2'b01; end
            5'd4, 5'd6: begin
                v.rd = 1'b1; v.wacc = 1'b1; v.sela = 2'b10; v.selb = 1'b0;
                v.op = (instr[15:11] == 5'd6);
            end
            5'd5, 5'd7: begin
                v.wacc = 1'b1; v.sela = 2'b10; v.selb = 1'b1;
                v.op = (instr[15:11] == 5'd7);
            end
            default: v.ill = 1'b1;
        endcase
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, DbgState, S_IDLE);
        chk({tag, "_pc"}, PC, 0);
        chk({tag, "_addr"}, DataAddr, 0);
        chk({tag, "_strobes"}, {RdRam, WrRam, WrAcc}, 0);
        chk({tag, "_sel"}, {SelA, SelB, Op}, 0);
        chk({tag, "_imm"}, Immediate, 0);
        chk({tag, "_halted"}, Halted, 0);
        chk({tag, "_illegal"}, IllegalOp, 0);
        chk({tag, "_count"}, InstrCount, 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    endtask

    task automatic do_reset();
        rand_start = 0;
        Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        mpc = '0; mcnt = '0; mill = 1'b0; halted_seen = 0;
        check_reset_vals("reset");
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(posedge Clk);
        #1;
        rand_start = 1;
        Start = 1'($urandom_range(0, 1));
    endtask

    // Runs one instruction from its FETCH cycle, checking every cycle
    task automatic step_instr(input vec_t v);
        logic [10:0] opnd;
        logic [15:0] imm;
        opnd = v.instr[10:0];
        imm  = {{5{v.instr[10]}}, v.instr[10:0]};
        chk("fetch_state", DbgState, S_FETCH);
        chk("fetch_pc", PC, mpc);
        chk("fetch_strobes", {RdRam, WrRam, WrAcc}, 0);
        tick();
        chk("decode_state", DbgState, S_DECODE);
        chk("decode_strobes", {RdRam, WrRam, WrAcc}, 0);
        chk("decode_halted", Halted, 0);
        if (v.instr[15:11] == 5'd0) begin
            tick();
            chk("halt_state", DbgState, S_HALTED);
            chk("halt_flag", Halted, 1);
            chk("halt_pc", PC, mpc);
            chk("halt_count", InstrCount, mcnt);
            chk("halt_strobes", {RdRam, WrRam, WrAcc}, 0);
            halted_seen = 1;
            return;
        end
        tick();
        chk("exec_rdram", RdRam, v.rd);
        chk("exec_wr", {WrRam, WrAcc}, 0);
        chk("exec_addr", DataAddr, opnd);
        chk("exec_illegal", IllegalOp, mill | v.ill);
        tick();
        chk("write_wrram", WrRam, v.wr);
        chk("write_wracc", WrAcc, v.wacc);
        chk("write_rdram", RdRam, 0);
        chk("write_imm", Immediate, imm);
        chk("write_addr", DataAddr, opnd);
        if (v.wacc) chk("write_sela", SelA, v.sela);
        if (v.wacc && v.sela == 2'b10) chk("write_selb_op", {SelB, Op}, {v.selb, v.op});
        mpc  = mpc + 11'd1;
        mcnt = mcnt + 16'd1;
        mill = mill | v.ill;
        tick();
    endtask

    task automatic run_prog(input int max_instr);
        for (int i = 0; i < max_instr && !halted_seen; i++)
            step_instr(model_vec(prog[mpc]));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main ----------------
    vec_t tbl [10];

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        rand_start = 0;
        clear_prog();

        tbl[0] = '{16'h0809, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}; // STO 9
        tbl[1] = '{16'h1007, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}; // LD 7
        tbl[2] = '{16'h1FFF, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0}; // LDI -1
        tbl[3] = '{16'h2003, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0}; // ADD 3
        tbl[4] = '{16'h2C00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0}; // ADDI -1024
        tbl[5] = '{16'h3008, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0}; // SUB 8
        tbl[6] = '{16'h3BFF, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0}; // SUBI 1023
        tbl[7] = '{16'hF800, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // 11111
        tbl[8] = '{16'h4123, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // 01000
        tbl[9] = '{16'hC7FF, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}; // 11000

        repeat (2) @(posedge Clk);
        #1;

        // LDI 5; ADDI -2; HLT, then stay halted with Start toggling
        clear_prog();
        prog[0] = 16'h1805; prog[1] = 16'h2FFE; prog[2] = 16'h0000;
        do_reset();
        do_start();
        run_prog(10);
        chk("t1_halt_reached", halted_seen, 1);
        chk("t1_pc", PC, 2);
        chk("t1_count", InstrCount, 2);
        chk("t1_last_imm", Immediate, 16'hFFFE);
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("hold_halted", {DbgState, Halted}, {S_HALTED, 1'b1});
            chk("hold_pc_count", {PC, InstrCount}, {11'd2, 16'd2});
        end

        // LD 7; SUB 8; STO 9; HLT
        clear_prog();
        prog[0] = 16'h1007; prog[1] = 16'h3008; prog[2] = 16'h0809; prog[3] = 16'h0000;
        do_reset();
        do_start();
        run_prog(10);
        chk("t2_halt_reached", halted_seen, 1);
        chk("t2_count", InstrCount, 3);
        chk("t2_illegal", IllegalOp, 0);

        // Opcode table: each entry followed by HLT
        for (int i = 0; i < 10; i++) begin
            clear_prog();
            prog[0] = tbl[i].instr;
            do_reset();
            do_start();
            step_instr(tbl[i]);
            step_instr(model_vec(16'h0000));
            chk("tbl_halt_reached", halted_seen, 1);
            chk("tbl_pc", PC, 1);
            chk("tbl_count", InstrCount, 1);
            chk("tbl_illegal_sticky", IllegalOp, tbl[i].ill);
        end

        // Random programs against the reference model
        for (int p = 0; p < 8; p++) begin
            int len;
            logic [4:0] opc;
            clear_prog();
            len = $urandom_range(4, 14);
            for (int k = 0; k < len; k++) begin
                opc = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(1, 7))
                                                 : 5'($urandom_range(8, 31));
                prog[k] = {opc, 11'($urandom)};
            end
            do_reset();
            do_start();
            run_prog(len + 1);
            chk("rand_halt_reached", halted_seen, 1);
            chk("rand_count", InstrCount, len);
        end

        // Reset asserted in EXEC of ADD (Start also high: Reset wins)
        clear_prog();
        prog[0] = 16'h1FFF; prog[1] = 16'h2005; prog[2] = 16'h0000;
        do_reset();
        do_start();
        run_prog(1);
        tick();
        tick();
        chk("rst_exec_rdram", RdRam, 1);
        chk("rst_exec_addr", DataAddr, 5);
        rand_start = 0;
        Start = 1'b1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Start = 1'b0;
        check_reset_vals("rst_exec");
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk);
            #1;
            chk("rst_no_write", {WrAcc, WrRam, RdRam}, 0);
            chk("rst_stay_idle", DbgState, S_IDLE);
        end

        // PC wrap after 2048 NOP-executed illegal opcodes
        clear_prog();
        for (int i = 0; i < 2048; i++) prog[i] = {5'b11000, 11'($urandom)};
        do_reset();
        do_start();
        run_prog(2047);
        chk("wrap_pc_2047", PC, 2047);
        run_prog(1);
        chk("wrap_pc_0", PC, 0);
        chk("wrap_count", InstrCount, 2048);
        chk("wrap_illegal", IllegalOp, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
